line_arbiter: RTL and testbench

- Responder for line-granular memory requests from two clients: the instruction cache (read-only) and the data-side eviction buffer (read or write).
- Serialises those requests onto the single line-level port toward the cacheline adaptor / physical memory.
- One transaction in flight at a time; fairness between clients is round-robin.
- Sits between the cache/eviction-buffer layer and the burst adaptor.

---
 rtl/line_arbiter_pkg.sv | 22 ++
 rtl/line_arbiter_if.sv | 41 ++++
 rtl/line_arbiter_reg.sv | 25 ++
 rtl/line_arbiter.sv | 139 +++++++++++++
 tb/tb_line_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_arbiter_pkg.sv
// Shared types and default widths for the line arbiter.
package line_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_LINE_W = 256;
    localparam int ARB_CNT_W  = 32;

    typedef logic [ARB_ADDR_W-1:0] rv32i_word;
    typedef logic [ARB_LINE_W-1:0] rv32i_line;

    typedef enum logic [1:0] {
        IDLE,
        I_SVC,
        D_SVC
    } arb_state_t;

    typedef enum logic {
        CLIENT_I,
        CLIENT_D
    } arb_client_t;

endpackage

// File: rtl/line_arbiter_if.sv
// Bundle of the two client ports and the memory-side line port.
// master: the arbiter's view. slave: the clients and the adaptor together.
interface line_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);

    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_resp;
    logic [LINE_W-1:0] mem_rdata;

    modport master (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
        input  mem_resp, mem_rdata,
        output i_resp, i_rdata, d_resp, d_rdata,
        output mem_read, mem_write, mem_address, mem_wdata
    );

    modport slave (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
        output mem_resp, mem_rdata,
        input  i_resp, i_rdata, d_resp, d_rdata,
        input  mem_read, mem_write, mem_address, mem_wdata
    );

endinterface

// File: rtl/line_arbiter_reg.sv
// Generic loadable register with synchronous active-high clear.
module line_arbiter_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);

    logic [WIDTH-1:0] data_q;

    // Capture the input whenever load is asserted; reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= in_i;
        end
    end

    assign out_o = data_q;

endmodule

// File: rtl/line_arbiter.sv
// Round-robin arbiter serialising I-cache reads and eviction-buffer
// reads/writebacks onto one line-level memory port, one at a time.
module line_arbiter
    import line_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W,
    parameter int CNT_W  = ARB_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    line_arbiter_if.master    bus,
    output logic [CNT_W-1:0]  i_grant_count,
    output logic [CNT_W-1:0]  d_grant_count,
    output logic [CNT_W-1:0]  conflict_count
);

    arb_state_t        state_q, state_d;
    arb_client_t       lastGrant_q, lastGrant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              opWrite_q, opWrite_d;

    logic iReq;
    logic dReq;
    logic iInc;
    logic dInc;
    logic conflictInc;

    assign iReq = bus.i_read;
    assign dReq = bus.d_read | bus.d_write;

    // State and the request latched at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= CLIENT_I;
            addr_q      <= '0;
            wdata_q     <= '0;
            opWrite_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            opWrite_q   <= opWrite_d;
        end
    end

    // Arbitration, memory-port drive and same-cycle completion responses.
    always_comb begin
        state_d         = state_q;
        lastGrant_d     = lastGrant_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        opWrite_d       = opWrite_q;
        iInc            = 1'b0;
        dInc            = 1'b0;
        conflictInc     = 1'b0;
        bus.i_resp      = 1'b0;
        bus.i_rdata     = '0;
        bus.d_resp      = 1'b0;
        bus.d_rdata     = '0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = '0;
        bus.mem_wdata   = '0;

        unique case (state_q)
            IDLE: begin
                conflictInc = iReq & dReq;
                if (dReq && (!iReq || lastGrant_q == CLIENT_I)) begin
                    state_d     = D_SVC;
                    lastGrant_d = CLIENT_D;
                    addr_d      = bus.d_address;
                    wdata_d     = bus.d_wdata;
                    opWrite_d   = bus.d_write;
                end else if (iReq) begin
                    state_d     = I_SVC;
                    lastGrant_d = CLIENT_I;
                    addr_d      = bus.i_address;
                    wdata_d     = '0;
                    opWrite_d   = 1'b0;
                end
            end
            I_SVC: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = addr_q;
                bus.mem_wdata   = wdata_q;
                if (bus.mem_resp) begin
                    bus.i_resp  = 1'b1;
                    bus.i_rdata = bus.mem_rdata;
                    iInc        = 1'b1;
                    state_d     = IDLE;
                end
            end
            D_SVC: begin
                bus.mem_read    = ~opWrite_q;
                bus.mem_write   = opWrite_q;
                bus.mem_address = addr_q;
                bus.mem_wdata   = wdata_q;
                if (bus.mem_resp) begin
                    bus.d_resp  = 1'b1;
                    bus.d_rdata = opWrite_q ? '0 : bus.mem_rdata;
                    dInc        = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    line_arbiter_reg #(.WIDTH(CNT_W)) iCountReg (
        .clk    (clk),
        .rst    (rst),
        .load_i (iInc),
        .in_i   (i_grant_count + CNT_W'(1)),
        .out_o  (i_grant_count)
    );

    line_arbiter_reg #(.WIDTH(CNT_W)) dCountReg (
        .clk    (clk),
        .rst    (rst),
        .load_i (dInc),
        .in_i   (d_grant_count + CNT_W'(1)),
        .out_o  (d_grant_count)
    );

    line_arbiter_reg #(.WIDTH(CNT_W)) conflictCountReg (
        .clk    (clk),
        .rst    (rst),
        .load_i (conflictInc),
        .in_i   (conflict_count + CNT_W'(1)),
        .out_o  (conflict_count)
    );

endmodule

// File: tb/tb_line_arbiter.sv
// Self-checking bench for line_arbiter: directed scenarios followed by a
// randomized run, all checked against a transaction-level reference model.
module tb_line_arbiter;
    import line_arbiter_pkg::*;

    localparam int ADDR_W = ARB_ADDR_W;
    localparam int LINE_W = ARB_LINE_W;
    localparam int CNT_W  = ARB_CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] iGrantCount;
    logic [CNT_W-1:0] dGrantCount;
    logic [CNT_W-1:0] conflictCount;

    line_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    line_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.master),
        .i_grant_count  (iGrantCount),
        .d_grant_count  (dGrantCount),
        .conflict_count (conflictCount)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: who currently owns the memory port (0 none, 1 I, 2 D),
    // who was granted last, the transaction captured at grant, and tallies.
    int               mOwner;
    arb_client_t      mLast;
    rv32i_word        mAddr;
    rv32i_line        mWdata;
    logic             mWrite;
    logic [CNT_W-1:0] mICnt;
    logic [CNT_W-1:0] mDCnt;
    logic [CNT_W-1:0] mConf;

    // The eviction buffer must never ask for a read and a write at once.
    always @(negedge clk) begin
        if (bus.d_read && bus.d_write) begin
            miscompares++;
            $error("[TB] FAIL illegal_d_op observed=d_read&d_write expected=one op");
        end
    end

    task automatic checkOutput(input string tag, input rv32i_line observed, input rv32i_line expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iRead, input rv32i_word iAddr,
                                 input logic dRead, input logic dWrite,
                                 input rv32i_word dAddr, input rv32i_line dWdata,
                                 input logic memResp, input rv32i_line memRdata);
        bus.i_read    = iRead;
        bus.i_address = iAddr;
        bus.d_read    = dRead;
        bus.d_write   = dWrite;
        bus.d_address = dAddr;
        bus.d_wdata   = dWdata;
        bus.mem_resp  = memResp;
        bus.mem_rdata = memRdata;
    endtask

    task automatic modelReset();
        mOwner = 0;
        mLast  = CLIENT_I;
        mAddr  = '0;
        mWdata = '0;
        mWrite = 1'b0;
        mICnt  = '0;
        mDCnt  = '0;
        mConf  = '0;
    endtask

    // Compare every output against what the model says this cycle should show.
    task automatic checkModel();
        logic      expIResp     = 1'b0;
        logic      expDResp     = 1'b0;
        logic      expMemRead   = 1'b0;
        logic      expMemWrite  = 1'b0;
        rv32i_word expAddr      = '0;
        rv32i_line expWdata     = '0;
        rv32i_line expIRdata    = '0;
        rv32i_line expDRdata    = '0;
        logic      checkWdata   = 1'b1;
        if (mOwner == 1) begin
            expMemRead = 1'b1;
            expAddr    = mAddr;
            checkWdata = 1'b0;
            if (bus.mem_resp) begin
                expIResp  = 1'b1;
                expIRdata = bus.mem_rdata;
            end
        end else if (mOwner == 2) begin
            expMemRead  = !mWrite;
            expMemWrite = mWrite;
            expAddr     = mAddr;
            expWdata    = mWdata;
            checkWdata  = mWrite;
            if (bus.mem_resp) begin
                expDResp  = 1'b1;
                expDRdata = mWrite ? '0 : bus.mem_rdata;
            end
        end
        checkOutput("mem_read",    LINE_W'(bus.mem_read),    LINE_W'(expMemRead));
        checkOutput("mem_write",   LINE_W'(bus.mem_write),   LINE_W'(expMemWrite));
        checkOutput("mem_address", LINE_W'(bus.mem_address), LINE_W'(expAddr));
        if (checkWdata) checkOutput("mem_wdata", bus.mem_wdata, expWdata);
        checkOutput("i_resp",      LINE_W'(bus.i_resp),      LINE_W'(expIResp));
        checkOutput("i_rdata",     bus.i_rdata,              expIRdata);
        checkOutput("d_resp",      LINE_W'(bus.d_resp),      LINE_W'(expDResp));
        checkOutput("d_rdata",     bus.d_rdata,              expDRdata);
        checkOutput("i_grant_count",  LINE_W'(iGrantCount),   LINE_W'(mICnt));
        checkOutput("d_grant_count",  LINE_W'(dGrantCount),   LINE_W'(mDCnt));
        checkOutput("conflict_count", LINE_W'(conflictCount), LINE_W'(mConf));
    endtask

    // Move the model across one clock edge using the inputs present at that edge.
    task automatic advance();
        logic      sRst    = rst;
        logic      sIRead  = bus.i_read;
        logic      sDRead  = bus.d_read;
        logic      sDWrite = bus.d_write;
        rv32i_word sIAddr  = bus.i_address;
        rv32i_word sDAddr  = bus.d_address;
        rv32i_line sDWdata = bus.d_wdata;
        logic      sResp   = bus.mem_resp;
        logic      dPend;
        @(posedge clk);
        dPend = sDRead | sDWrite;
        if (sRst) begin
            modelReset();
        end else if (mOwner == 0) begin
            if (sIRead && dPend) mConf = mConf + CNT_W'(1);
            if (dPend && (!sIRead || mLast == CLIENT_I)) begin
                mOwner = 2;
                mLast  = CLIENT_D;
                mAddr  = sDAddr;
                mWdata = sDWdata;
                mWrite = sDWrite;
            end else if (sIRead) begin
                mOwner = 1;
                mLast  = CLIENT_I;
                mAddr  = sIAddr;
                mWrite = 1'b0;
            end
        end else if (sResp) begin
            if (mOwner == 1) mICnt = mICnt + CNT_W'(1);
            else             mDCnt = mDCnt + CNT_W'(1);
            mOwner = 0;
        end
        #1;
    endtask

    task automatic sampleStep();
        @(negedge clk);
        checkModel();
    endtask

    task automatic cycle();
        sampleStep();
        advance();
    endtask

    initial begin
        rv32i_line lineA = {32{8'hAA}};
        rv32i_line line5 = {32{8'h55}};
        rv32i_line junk;
        logic      rI, rD, rW;
        rv32i_word rIAddr, rDAddr;
        rv32i_line rDWdata;
        logic      rResp;

        modelReset();
        rst = 1'b1;
        applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
        cycle();
        cycle();
        rst = 1'b0;

        // Lone I-cache read of 0x100, memory answers on the third service cycle.
        applyStimulus(1, 32'h0000_0100, 0, 0, '0, '0, 0, '0);
        cycle();
        for (int k = 0; k < 2; k++) begin
            sampleStep();
            checkOutput("t1_mem_read", LINE_W'(bus.mem_read), LINE_W'(1'b1));
            checkOutput("t1_mem_addr", LINE_W'(bus.mem_address), LINE_W'(32'h100));
            advance();
        end
        applyStimulus(1, 32'h0000_0100, 0, 0, '0, '0, 1, lineA);
        sampleStep();
        checkOutput("t1_i_resp",  LINE_W'(bus.i_resp), LINE_W'(1'b1));
        checkOutput("t1_i_rdata", bus.i_rdata, lineA);
        advance();
        applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
        sampleStep();
        checkOutput("t1_i_count", LINE_W'(iGrantCount), LINE_W'(1));
        advance();

        // Lone writeback to 0x2040; read data from memory must not leak out.
        applyStimulus(0, '0, 0, 1, 32'h0000_2040, line5, 0, '0);
        cycle();
        sampleStep();
        checkOutput("t2_mem_write", LINE_W'(bus.mem_write), LINE_W'(1'b1));
        checkOutput("t2_mem_addr",  LINE_W'(bus.mem_address), LINE_W'(32'h2040));
        checkOutput("t2_mem_wdata", bus.mem_wdata, line5);
        advance();
        applyStimulus(0, '0, 0, 1, 32'h0000_2040, line5, 1, lineA);
        sampleStep();
        checkOutput("t2_d_resp",  LINE_W'(bus.d_resp), LINE_W'(1'b1));
        checkOutput("t2_d_rdata", bus.d_rdata, '0);
        advance();
        applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
        sampleStep();
        checkOutput("t2_d_count", LINE_W'(dGrantCount), LINE_W'(1));
        advance();

        // Simultaneous requests right after reset: D first, bubble, then I.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        applyStimulus(1, 32'h0000_0400, 1, 0, 32'h0000_0500, '0, 0, '0);
        cycle();
        applyStimulus(1, 32'h0000_0400, 1, 0, 32'h0000_0500, '0, 1, line5);
        sampleStep();
        checkOutput("t3_first_addr", LINE_W'(bus.mem_address), LINE_W'(32'h500));
        checkOutput("t3_d_resp",     LINE_W'(bus.d_resp), LINE_W'(1'b1));
        advance();
        applyStimulus(1, 32'h0000_0400, 0, 0, '0, '0, 0, '0);
        sampleStep();
        checkOutput("t3_bubble", LINE_W'(bus.mem_read), LINE_W'(1'b0));
        advance();
        applyStimulus(1, 32'h0000_0400, 0, 0, '0, '0, 1, lineA);
        sampleStep();
        checkOutput("t3_second_addr", LINE_W'(bus.mem_address), LINE_W'(32'h400));
        checkOutput("t3_conflicts",   LINE_W'(conflictCount), LINE_W'(1));
        advance();
        applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
        cycle();

        // Back-to-back D read then D write; address wiggle during service ignored.
        junk = {8{$urandom}};
        applyStimulus(0, '0, 1, 0, 32'h0000_0300, '0, 0, '0);
        cycle();
        applyStimulus(0, '0, 1, 0, 32'h0000_FFF0, '0, 0, '0);
        sampleStep();
        checkOutput("t4_held_addr", LINE_W'(bus.mem_address), LINE_W'(32'h300));
        advance();
        applyStimulus(0, '0, 1, 0, 32'h0000_FFF0, '0, 1, junk);
        sampleStep();
        checkOutput("t4_d_rdata", bus.d_rdata, junk);
        advance();
        applyStimulus(0, '0, 0, 1, 32'h0000_0700, line5, 0, '0);
        cycle();
        applyStimulus(0, '0, 0, 1, 32'h0000_0700, line5, 1, junk);
        sampleStep();
        checkOutput("t4_write_addr", LINE_W'(bus.mem_address), LINE_W'(32'h700));
        checkOutput("t4_write_op",   LINE_W'(bus.mem_write), LINE_W'(1'b1));
        advance();
        applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
        cycle();

        // Reset lands during I service before memory answers.
        applyStimulus(1, 32'h0000_0900, 0, 0, '0, '0, 0, '0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        applyStimulus(0, '0, 0, 0, '0, '0, 1, lineA);
        sampleStep();
        checkOutput("t5_mem_read", LINE_W'(bus.mem_read), LINE_W'(1'b0));
        checkOutput("t5_i_resp",   LINE_W'(bus.i_resp), LINE_W'(1'b0));
        checkOutput("t5_counts",   LINE_W'({iGrantCount, dGrantCount, conflictCount}), '0);
        advance();

        // Stray memory responses while idle with nobody asking.
        cycle();
        sampleStep();
        checkOutput("t6_no_resp", LINE_W'({bus.i_resp, bus.d_resp}), '0);
        checkOutput("t6_counts",  LINE_W'({iGrantCount, dGrantCount, conflictCount}), '0);
        advance();

        // Randomized traffic: clients hold requests until answered.
        rI = 1'b0; rD = 1'b0; rW = 1'b0;
        rIAddr = '0; rDAddr = '0; rDWdata = '0;
        for (int n = 0; n < 500; n++) begin
            rst   = ($urandom_range(0, 79) == 0);
            rResp = !rst && ($urandom_range(0, 2) == 0);
            if (!rI && $urandom_range(0, 3) == 0) begin
                rI     = 1'b1;
                rIAddr = $urandom & 32'hFFFF_FFE0;
            end
            if (!rD && $urandom_range(0, 3) == 0) begin
                rD      = 1'b1;
                rW      = $urandom_range(0, 1) == 1;
                rDAddr  = $urandom & 32'hFFFF_FFE0;
                rDWdata = {8{$urandom}};
            end
            if ($urandom_range(0, 5) == 0) rDAddr = $urandom;
            if ($urandom_range(0, 5) == 0) rIAddr = $urandom;
            applyStimulus(rI, rIAddr, rD && !rW, rD && rW, rDAddr, rDWdata, rResp, {8{$urandom}});
            sampleStep();
            if (bus.i_resp) rI = 1'b0;
            if (bus.d_resp) rD = 1'b0;
            advance();
        end
        rst = 1'b0;
        applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
